// File: rtl/mlp_pkg.sv
// Shared constants, types and helpers for the MLP neuron processing unit.
package mlp_pkg;

    localparam int unsigned N_INPUTS  = 62;
    localparam int unsigned DW        = 8;
    localparam int unsigned ACC_W     = 24;
    localparam int unsigned FRAC_BITS = 7;
    localparam int unsigned MAG_W     = DW - 1;
    localparam int unsigned PROD_W    = 2 * MAG_W + 1;
    localparam int unsigned IDX_W     = $clog2(N_INPUTS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_t;

    // Sign-magnitude Q0.7 value aligned to Q0.14 in two's complement; -0 maps to +0.
    function automatic logic [ACC_W-1:0] sm_to_q14(input sm_t x);
        logic [ACC_W-1:0] mag_q14;
        mag_q14 = ACC_W'(x.mag) << FRAC_BITS;
        return x.sign ? (ACC_W'(0) - mag_q14) : mag_q14;
    endfunction

endpackage

// File: rtl/sm_mult.sv
// Sign-magnitude DW x DW multiplier producing a signed two's-complement Q0.14 product.
module sm_mult
    import mlp_pkg::*;
(
    input  sm_t                      a,
    input  sm_t                      w,
    output logic signed [PROD_W-1:0] prod_c
);

    logic [2*MAG_W-1:0] mag_c;
    logic               neg_c;

    // A zero magnitude yields +0 regardless of operand signs.
    always_comb begin
        mag_c  = (2*MAG_W)'(a.mag) * (2*MAG_W)'(w.mag);
        neg_c  = (a.sign ^ w.sign) && (mag_c != '0);
        prod_c = neg_c ? -$signed({1'b0, mag_c}) : $signed({1'b0, mag_c});
    end

endmodule

// File: rtl/mlp_neuron_pu.sv
// Single MLP neuron: serial 62-term sign-magnitude MAC, bias, scale back to Q0.7.
// Macro PU_RELU_EN selects ReLU output; otherwise the output is linear sign-magnitude.
module mlp_neuron_pu
    import mlp_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [N_INPUTS*DW-1:0] inp,
    input  logic [N_INPUTS*DW-1:0] weights,
    input  logic [DW-1:0]          bias,
    output logic [DW-1:0]          result,
    output logic                   ready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
    localparam logic [ACC_W-1:0] MAG_MAX  = ACC_W'((1 << MAG_W) - 1);

    state_t                   state;
    logic [ACC_W-1:0]         acc;
    logic [IDX_W-1:0]         idx;

    sm_t                      a_el_c;
    sm_t                      w_el_c;
    logic signed [PROD_W-1:0] prod_c;
    logic [ACC_W-1:0]         mac_sum_c;
    logic [ACC_W-1:0]         fin_sum_c;
    logic [ACC_W-1:0]         abs_c;
    logic [ACC_W-1:0]         shifted_c;
    logic [MAG_W-1:0]         m_c;
    logic                     neg_c;
    logic [DW-1:0]            act_c;

    // Inputs are read live; the current element is selected by idx.
    assign a_el_c = sm_t'(inp[DW*idx +: DW]);
    assign w_el_c = sm_t'(weights[DW*idx +: DW]);

    sm_mult u_mult (
        .a      (a_el_c),
        .w      (w_el_c),
        .prod_c (prod_c)
    );

    // Accumulate, add the aligned bias, then truncate |sum| toward zero and saturate.
    always_comb begin
        mac_sum_c = acc + {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
        fin_sum_c = acc + sm_to_q14(sm_t'(bias));
        neg_c     = fin_sum_c[ACC_W-1];
        abs_c     = neg_c ? (ACC_W'(0) - fin_sum_c) : fin_sum_c;
        shifted_c = abs_c >> FRAC_BITS;
        m_c       = (shifted_c > MAG_MAX) ? MAG_W'(MAG_MAX) : shifted_c[MAG_W-1:0];
`ifdef PU_RELU_EN
        act_c     = (neg_c || (fin_sum_c == '0)) ? DW'(0) : {1'b0, m_c};
`else
        act_c     = {neg_c && (m_c != '0), m_c};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            ready  <= 1'b0;
            acc    <= '0;
            idx    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= MAC;
                        acc   <= '0;
                        idx   <= '0;
                        ready <= 1'b0;
                    end
                end
                MAC: begin
                    acc <= mac_sum_c;
                    if (idx == LAST_IDX) begin
                        state <= FIN;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                FIN: begin
                    result <= act_c;
                    ready  <= 1'b1;
                    state  <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_neuron_pu.sv
// Directed self-checking bench for mlp_neuron_pu.
module tb_mlp_neuron_pu;

    localparam int NI = 62;
    localparam int LAT = 63;

    logic            clk;
    logic            rst;
    logic            start;
    logic [NI*8-1:0] inp;
    logic [NI*8-1:0] weights;
    logic [7:0]      bias;
    logic [7:0]      result;
    logic            ready;

    int total;
    int bad;

    mlp_neuron_pu dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .inp     (inp),
        .weights (weights),
        .bias    (bias),
        .result  (result),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic fill(input logic [7:0] a, input logic [7:0] w, input logic [7:0] b);
        for (int i = 0; i < NI; i++) begin
            inp[i*8 +: 8]     = a;
            weights[i*8 +: 8] = w;
        end
        bias = b;
    endtask

    // Pulse start, optionally re-pulse at cycle 'extra', return edges until ready (-1 on timeout).
    task automatic run_op(input int extra, output int lat, output logic rdy0, output logic [7:0] res0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        rdy0 = ready;
        res0 = result;
        lat  = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = i;
                break;
            end
            start = (i == extra);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if (result !== 8'h00) begin bad++; $display("FAIL reset_result: got %h want 00", result); end
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
        total++;
        if (dut.state !== mlp_pkg::IDLE) begin bad++; $display("FAIL reset_state: got %0d want 0", dut.state); end
    endtask

    task automatic test_latency();
        int lat; logic r0; logic [7:0] s0;
        fill(8'h40, 8'h40, 8'h00);
        run_op(-1, lat, r0, s0);
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL latency: got %0d want %0d", lat, LAT); end
        total++;
        if (result !== 8'h7F) begin bad++; $display("FAIL saturate: got %h want 7f", result); end
    endtask

    task automatic test_single_bias();
        int lat; logic r0; logic [7:0] s0;
        fill(8'h40, 8'h00, 8'h05);
        weights[7:0] = 8'h20;
        run_op(-1, lat, r0, s0);
        total++;
        if (lat !== LAT || result !== 8'h15) begin
            bad++; $display("FAIL single_bias: got %h lat %0d want 15 lat %0d", result, lat, LAT);
        end
    endtask

    task automatic test_negative();
        int lat; logic r0; logic [7:0] s0; logic [7:0] exp_v;
`ifdef PU_RELU_EN
        exp_v = 8'h00;
`else
        exp_v = 8'h90;
`endif
        fill(8'h40, 8'h00, 8'h00);
        weights[7:0] = 8'hA0;
        run_op(-1, lat, r0, s0);
        total++;
        if (result !== exp_v) begin bad++; $display("FAIL negative: got %h want %h", result, exp_v); end
    endtask

    task automatic test_neg_zero();
        int lat; logic r0; logic [7:0] s0;
        fill(8'h7F, 8'h80, 8'h80);
        run_op(-1, lat, r0, s0);
        total++;
        if (result !== 8'h00) begin bad++; $display("FAIL neg_zero: got %h want 00", result); end
        // Sum of -1 (Q0.14) truncates to magnitude 0 and must never read as 0x80.
        fill(8'h00, 8'h00, 8'h00);
        inp[7:0]     = 8'h01;
        weights[7:0] = 8'h81;
        run_op(-1, lat, r0, s0);
        total++;
        if (result !== 8'h00) begin bad++; $display("FAIL tiny_negative: got %h want 00", result); end
    endtask

    task automatic test_mixed();
        int lat; logic r0; logic [7:0] s0;
        // 16129 - 127 - 128 = 15874 -> 124
        fill(8'h11, 8'h00, 8'h81);
        inp[7:0]      = 8'h7F; weights[7:0]  = 8'h7F;
        inp[15:8]     = 8'hFF; weights[15:8] = 8'h01;
        run_op(-1, lat, r0, s0);
        total++;
        if (result !== 8'h7C) begin bad++; $display("FAIL mixed: got %h want 7c", result); end
    endtask

    task automatic test_back_to_back();
        int lat; logic r0; logic [7:0] s0; logic [7:0] exp_v;
        fill(8'h40, 8'h00, 8'h05);
        weights[7:0] = 8'h20;
        run_op(10, lat, r0, s0);
        total++;
        if (lat !== LAT) begin bad++; $display("FAIL start_in_mac_latency: got %0d want %0d", lat, LAT); end
        total++;
        if (result !== 8'h15) begin bad++; $display("FAIL start_in_mac_result: got %h want 15", result); end
        // Restart from DONE with a negative-sum vector.
        repeat (3) @(posedge clk);
        #1;
        fill(8'h40, 8'h00, 8'h00);
        weights[7:0] = 8'hA0;
`ifdef PU_RELU_EN
        exp_v = 8'h00;
`else
        exp_v = 8'h90;
`endif
        run_op(-1, lat, r0, s0);
        total++;
        if (r0 !== 1'b0) begin bad++; $display("FAIL done_restart_ready_drop: got %b want 0", r0); end
        total++;
        if (s0 !== 8'h15) begin bad++; $display("FAIL done_restart_hold: got %h want 15", s0); end
        total++;
        if (lat !== LAT || result !== exp_v) begin
            bad++; $display("FAIL done_restart: got %h lat %0d want %h lat %0d", result, lat, exp_v, LAT);
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic r0; logic [7:0] s0;
        fill(8'h40, 8'h40, 8'h00);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        total++;
        if (result !== 8'h00 || ready !== 1'b0) begin
            bad++; $display("FAIL reset_mid_outputs: got %h/%b want 00/0", result, ready);
        end
        total++;
        if (dut.state !== mlp_pkg::IDLE) begin bad++; $display("FAIL reset_mid_state: got %0d want 0", dut.state); end
        fill(8'h40, 8'h00, 8'h05);
        weights[7:0] = 8'h20;
        run_op(-1, lat, r0, s0);
        total++;
        if (lat !== LAT || result !== 8'h15) begin
            bad++; $display("FAIL reset_mid_restart: got %h lat %0d want 15 lat %0d", result, lat, LAT);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        start   = 1'b0;
        inp     = '0;
        weights = '0;
        bias    = '0;
        test_reset();
        test_latency();
        test_single_bias();
        test_negative();
        test_neg_zero();
        test_mixed();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mlp_neuron_pu.md
Name: mlp_neuron_pu

Overview:
- One neuron processing unit of the MNIST MLP datapath. Eight instances run in parallel.
- Computes a 62-term sign-magnitude dot product of inputs and weights, adds a bias, applies ReLU, and returns an 8-bit sign-magnitude activation.
- Hidden layer: real 62-input neurons. Output layer: 30 inputs with weights zero-padded to 62.
- Start/ready handshake toward the datapath controller.

Parameters:
- N_INPUTS, 62, number of input/weight elements.
- DW, 8, element width: sign-magnitude, bit7 = sign, bits[6:0] = magnitude in Q0.7.
- ACC_W, 24, width of the two's-complement accumulator.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a computation.
- inp  in  N_INPUTS*DW  input vector; element i is inp[8i+:8].
- weights  in  N_INPUTS*DW  weight vector; element i is weights[8i+:8].
- bias  in  DW  sign-magnitude bias.
- result  out  DW  sign-magnitude activation, registered.
- ready  out  1  high while result is valid, registered.

Behaviour:
- Reset: state=IDLE, result=0x00, ready=0, acc=0, idx=0.
- States and transitions:
  - IDLE: on start go to MAC; acc=0, idx=0, ready=0.
  - MAC: each edge adds the product of element idx to acc, then idx++. After idx=61 is accumulated, go to FIN.
  - FIN: takes one edge. Register result and set ready=1, then go to DONE.
  - DONE: hold result and ready. On start, behave as in IDLE (ready drops on that edge).
- Latency: start sampled at edge k → ready=1 and result valid after edge k+63. That is 62 MAC edges plus 1 FIN edge.
- start while in MAC or FIN is ignored.
- inp, weights and bias are read live, not captured. Upstream must hold them stable from start until ready.
- Product rule:
  - magnitude = mag(a)*mag(w), 14 bits, Q0.14.
  - sign = sign(a) XOR sign(w).
  - Convert to two's complement before adding to acc.
  - A zero magnitude gives +0, so 0x80 counts as zero.
- Bias is aligned to Q0.14: the magnitude is shifted left by 7, sign applied, then added in FIN.
- Scaling back to Q0.7: m = |acc| >> 7 (symmetric truncation toward zero). If m > 127, saturate m to 127.
- Activation: if acc ≤ 0, result = 0x00; otherwise result = {0, m[6:0]}.
- ACC_W=24 is enough for 62 × 16129 plus the bias; no overflow is possible.
- Reset asserted mid-operation returns to the reset state; the partial accumulation is discarded.

Optional Feature:
- Macro: PU_RELU_EN.
- When defined: ReLU as described, so negative sums give 0x00.
- When undefined: linear output, result = {acc<0, m[6:0]} with the same saturation, and a zero magnitude always gives 0x00 (never 0x80).

Decomposition:
- Package mlp_pkg:
  - constants N_INPUTS, DW, ACC_W, FRAC_BITS=7;
  - state enum {IDLE, MAC, FIN, DONE};
  - sign-magnitude element typedef.
- One sub-module, sm_mult: DW×DW sign-magnitude operands → signed 15-bit two's-complement product.

Test Plan:
- Latency: all inp=0x40, all weights=0x40, bias=0x00, start pulse. Sum is 253952, >>7 = 1984, so result=0x7F (saturated). ready rises exactly 63 cycles after start.
- Single term with bias: inp[0]=0x40, weights[0]=0x20, all other weights=0x00, bias=0x05. acc=2048+640=2688 → result=0x15.
- Negative sum: inp[0]=0x40, weights[0]=0xA0, other weights=0x00, bias=0x00. With PU_RELU_EN → result=0x00. Without it → result=0x90.
- Negative zero: weights all 0x80, inp all 0x7F, bias=0x80 → result=0x00.
- Handshake: a second start during MAC is ignored and ready timing is unchanged. A start in DONE drops ready on the next edge, and the new result appears 63 cycles later.
- Reset: rst asserted at MAC cycle 30 → result=0x00, ready=0, state IDLE. A fresh start then completes normally with the correct value.
